// File: rtl/wl_row_sequencer.sv
// Wordline row sequencer: steps the decoder address through a burst of rows, pulsing wl_en per row.
// The optional abort input is enabled by defining SEQ_ABORT_EN.
module wl_row_sequencer #(
    parameter int unsigned NUM_ROWS       = 162,
    parameter int unsigned SETUP_CYCLES   = 1,
    parameter int unsigned RECOVER_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] row_base,
    input  logic [7:0] row_count,
    input  logic [3:0] pulse_cycles,
    input  logic       sense_rdy,
`ifdef SEQ_ABORT_EN
    input  logic       abort,
`endif
    output logic [7:0] add8,
    output logic       wl_en,
    output logic       busy,
    output logic       done,
    output logic       row_strobe
);

    localparam int unsigned MaxPhase = (SETUP_CYCLES > RECOVER_CYCLES) ? SETUP_CYCLES
                                                                      : RECOVER_CYCLES;
    localparam int unsigned MaxCnt   = (MaxPhase > 16) ? MaxPhase : 16;
    localparam int unsigned CntW     = $clog2(MaxCnt + 1);

    localparam logic [CntW-1:0] SetupLast   = CntW'(SETUP_CYCLES - 1);
    localparam logic [CntW-1:0] RecoverLast = CntW'(RECOVER_CYCLES - 1);
    localparam logic [7:0]      LastRow     = 8'(NUM_ROWS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StPulse,
        StRecover,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [7:0]      remaining_q, remaining_d;
    logic [7:0]      add8_q, add8_d;
    logic [3:0]      pulse_q, pulse_d;
    logic            wl_en_q, wl_en_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            row_strobe_q, row_strobe_d;
    logic            abort_req;
    logic [CntW-1:0] pulse_last;

`ifdef SEQ_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign pulse_last = CntW'(pulse_q - 4'd1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        remaining_d = remaining_q;
        add8_d      = add8_q;
        pulse_d     = pulse_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (row_count != 8'd0) begin
                        state_d     = StSetup;
                        cnt_d       = '0;
                        add8_d      = 8'(32'(row_base) % NUM_ROWS);
                        remaining_d = row_count;
                        pulse_d     = (pulse_cycles == 4'd0) ? 4'd1 : pulse_cycles;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StSetup: begin
                if (cnt_q == SetupLast) begin
                    state_d = StPulse;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StPulse: begin
                if (cnt_q == pulse_last) begin
                    state_d = StRecover;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRecover: begin
                // Minimum recovery first, then wait on the sense path.
                if (cnt_q == RecoverLast) begin
                    if (sense_rdy) begin
                        remaining_d = remaining_q - 8'd1;
                        cnt_d       = '0;
                        if (remaining_q != 8'd1) begin
                            state_d = StSetup;
                            add8_d  = (add8_q == LastRow) ? 8'd0 : add8_q + 8'd1;
                        end else begin
                            state_d = StDone;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (abort_req && (state_q inside {StSetup, StPulse, StRecover})) begin
            state_d = StDone;
        end

        // Outputs are decoded from the next state so they come straight off flops.
        wl_en_d      = (state_d == StPulse);
        busy_d       = (state_d inside {StSetup, StPulse, StRecover});
        done_d       = (state_d == StDone);
        row_strobe_d = (state_d == StPulse) && (cnt_d == pulse_last);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            remaining_q  <= 8'd0;
            add8_q       <= 8'd0;
            pulse_q      <= 4'd0;
            wl_en_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            row_strobe_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            remaining_q  <= remaining_d;
            add8_q       <= add8_d;
            pulse_q      <= pulse_d;
            wl_en_q      <= wl_en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            row_strobe_q <= row_strobe_d;
        end
    end

    assign add8       = add8_q;
    assign wl_en      = wl_en_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign row_strobe = row_strobe_q;

endmodule

// File: tb/tb_wl_row_sequencer.sv
// Scoreboard bench for wl_row_sequencer: stimulus pushes expected rows/done, monitor pops on DUT events.
module tb_wl_row_sequencer;

    localparam int NROWS = 162;
    localparam int SETUP = 1;
    localparam int RECOV = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] row_base = 8'd0;
    logic [7:0] row_count = 8'd0;
    logic [3:0] pulse_cycles = 4'd0;
    logic       sense_rdy = 1'b1;
    logic       abort = 1'b0;
    logic [7:0] add8;
    logic       wl_en, busy, done, row_strobe;

    wl_row_sequencer #(
        .NUM_ROWS      (NROWS),
        .SETUP_CYCLES  (SETUP),
        .RECOVER_CYCLES(RECOV)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .row_base    (row_base),
        .row_count   (row_count),
        .pulse_cycles(pulse_cycles),
        .sense_rdy   (sense_rdy),
`ifdef SEQ_ABORT_EN
        .abort       (abort),
`endif
        .add8        (add8),
        .wl_en       (wl_en),
        .busy        (busy),
        .done        (done),
        .row_strobe  (row_strobe)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit   is_done;
        int   addr;
        int   width;
        bit   strobe;
        int   busy_cycles;  // -1: not checked
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   stall_mode = 1'b0;
    bit   hold_sense = 1'b0;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    // Sense path model: random back-pressure in stall mode, otherwise always ready.
    always @(negedge clk) begin
        if (!hold_sense) sense_rdy = stall_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    // Monitor
    bit       prev_wl = 0;
    bit [7:0] prev_add8 = 0;
    int       run_len = 0, run_addr = 0, strobes = 0, low_cnt = 0, busy_cnt = 0;
    bit       strobe_last = 0, row_in_burst = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_wl = 0; prev_add8 = 0; run_len = 0; strobes = 0;
            low_cnt = 0; busy_cnt = 0; row_in_burst = 0;
        end else begin
            exp_t e;
            if (busy) busy_cnt++;
            if (wl_en) chk("add8_stable", add8, prev_add8);
            else chk("strobe_while_low", row_strobe, 0);
            if (wl_en && !prev_wl) begin
                if (row_in_burst) chk("row_gap_ok", int'(low_cnt >= SETUP + RECOV), 1);
                run_len = 0; run_addr = add8; strobes = 0; strobe_last = 0;
            end
            if (wl_en) begin
                run_len++;
                strobes += row_strobe;
                strobe_last = row_strobe;
            end
            if (!wl_en && prev_wl) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_row", run_addr, -1);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_kind_row", e.is_done, 0);
                    chk("row_addr", run_addr, e.addr);
                    chk("row_width", run_len, e.width);
                    chk("row_strobe", int'(strobes == 1 && strobe_last), e.strobe);
                end
                row_in_burst = 1;
            end
            if (wl_en) low_cnt = 0; else low_cnt++;
            if (done) begin
                chk("done_busy_low", busy, 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_kind_done", e.is_done, 1);
                    if (e.busy_cycles >= 0) chk("busy_cycles", busy_cnt, e.busy_cycles);
                end
                busy_cnt = 0;
                row_in_burst = 0;
            end
            prev_wl = wl_en;
            prev_add8 = add8;
        end
    end

    // Reference model: row i of a burst sits at (base mod N + i) mod N.
    task automatic push_burst(input int base, input int count, input int pulse, input bit stall);
        exp_t e;
        int w = (pulse == 0) ? 1 : pulse;
        for (int i = 0; i < count; i++) begin
            e.is_done = 0; e.addr = ((base % NROWS) + i) % NROWS; e.width = w;
            e.strobe = 1; e.busy_cycles = -1;
            exp_q.push_back(e);
        end
        e.is_done = 1; e.addr = 0; e.width = 0; e.strobe = 0;
        e.busy_cycles = stall ? -1 : count * (SETUP + w + RECOV);
        exp_q.push_back(e);
    endtask

    task automatic issue_start(input int base, input int count, input int pulse);
        @(negedge clk);
        row_base = 8'(base); row_count = 8'(count); pulse_cycles = 4'(pulse);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        // Scramble inputs to show they were latched.
        row_base = 8'($urandom); row_count = 8'($urandom); pulse_cycles = 4'($urandom);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    task automatic run_burst(input int base, input int count, input int pulse, input bit stall);
        stall_mode = stall;
        push_burst(base, count, pulse, stall);
        issue_start(base, count, pulse);
        @(negedge clk);
        chk("first_cycle_busy", busy, int'(count != 0));
        chk("first_cycle_done", done, int'(count == 0));
        chk("first_cycle_wl_en", wl_en, 0);
        wait_done();
        stall_mode = 0;
    endtask

    initial begin
        int n;
        #2;
        chk("reset_add8", add8, 0);
        chk("reset_wl_en", wl_en, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_strobe", row_strobe, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_burst(5, 3, 2, 0);
        run_burst(160, 4, 1, 0);
        run_burst(7, 0, 3, 0);
        run_burst(200, 2, 0, 0);
        run_burst(161, 1, 15, 0);

        // Sense path held off in row 0's recovery.
        hold_sense = 1; sense_rdy = 0;
        push_burst(0, 2, 1, 1);
        issue_start(0, 2, 1);
        n = 0;
        while (!(prev_wl && !wl_en) && n < 50) begin @(negedge clk); n++; end
        for (int i = 0; i < 10; i++) begin
            chk("stall_wl_en", wl_en, 0);
            chk("stall_add8", add8, 0);
            if (i < 9) @(negedge clk);
        end
        sense_rdy = 1;
        @(negedge clk);
        chk("resume_setup_add8", add8, 1);
        chk("resume_setup_wl_en", wl_en, 0);
        @(negedge clk);
        chk("resume_pulse_wl_en", wl_en, 1);
        hold_sense = 0;
        wait_done();

        for (int k = 0; k < 12; k++) begin
            run_burst($urandom_range(0, 255), $urandom_range(0, 5), $urandom_range(0, 15),
                      bit'($urandom_range(0, 1)));
        end

        // Reset in the middle of a pulse.
        issue_start(20, 5, 4);
        n = 0;
        while (!wl_en && n < 50) begin @(negedge clk); n++; end
        chk("rst_reached_pulse", wl_en, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_wl_en", wl_en, 0);
        chk("rst_async_busy", busy, 0);
        chk("rst_async_add8", add8, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("post_rst_idle", {29'd0, busy, done, wl_en}, 0);
        end
        run_burst(3, 2, 3, 0);

`ifdef SEQ_ABORT_EN
        begin
            exp_t e;
            int rises = 0;
            bit pw = 0;
            e.is_done = 0; e.addr = 10; e.width = 3; e.strobe = 1; e.busy_cycles = -1;
            exp_q.push_back(e);
            e.addr = 11; e.width = 1; e.strobe = 0;
            exp_q.push_back(e);
            e.is_done = 1; e.addr = 0; e.width = 0; e.busy_cycles = 8;
            exp_q.push_back(e);
            issue_start(10, 4, 3);
            n = 0;
            while (rises < 2 && n < 100) begin
                @(negedge clk);
                if (wl_en && !pw) rises++;
                pw = wl_en;
                n++;
            end
            abort = 1;
            @(negedge clk);
            abort = 0;
            chk("abort_wl_en", wl_en, 0);
            chk("abort_done", done, 1);
            repeat (10) @(negedge clk);
            chk("abort_no_rows", {31'd0, busy}, 0);
        end
`endif

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
